trng_key_fetch_master: RTL and testbench

//  Wishbone initiator that drives the TRNG slave. On start_i it writes the ring-oscillator trim word, then reads
//  KEY_WORDS 32-bit random words, health-checks each word, and assembles them into key_o for the secure-memory key path.

---
 rtl/trng_key_fetch_master_pkg.sv | 31 +++
 rtl/trng_key_fetch_master_if.sv | 20 ++
 rtl/trng_key_fetch_master_health_check.sv | 24 ++
 rtl/trng_key_fetch_master.sv | 211 +++++++++++++++++++++
 tb/tb_trng_key_fetch_master.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trng_key_fetch_master_pkg.sv
// Shared definitions for the TRNG key-fetch initiator: FSM encodings,
// trim data-bit positions, stuck-word patterns and the trim-word builder.
package trng_key_fetch_master_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIM_WR = 3'd1;
  localparam logic [2:0] ST_RD_REQ  = 3'd2;
  localparam logic [2:0] ST_RD_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ERR     = 3'd5;

  // Trim word layout inside the 32-bit write data
  localparam int unsigned TRIM_SEL_BIT = 5;
  localparam int unsigned TRIM_LVL_MSB = 1;
  localparam int unsigned TRIM_LVL_LSB = 0;

  // Patterns a stuck ring oscillator produces
  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;
  localparam logic [31:0] WORD_ONES = 32'hFFFF_FFFF;

  // Build the trim write data from the 3-bit trim configuration
  function automatic logic [31:0] trim_wdata(input logic [2:0] trim);
    logic [31:0] d;
    d = 32'h0000_0000;
    d[TRIM_SEL_BIT] = trim[2];
    d[TRIM_LVL_MSB:TRIM_LVL_LSB] = trim[1:0];
    return d;
  endfunction

endpackage

// File: rtl/trng_key_fetch_master_if.sv
// Point-to-point Wishbone link between the key-fetch initiator and the TRNG.
interface trng_key_fetch_master_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [8:0]  adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w,
    output dat_r, ack
  );
endinterface

// File: rtl/trng_key_fetch_master_health_check.sv
// Combinational health check on one random word: flags stuck-at patterns and
// a word that repeats the previously accepted one.
module trng_key_fetch_master_health_check
  import trng_key_fetch_master_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] prev_word,
  input  logic        first_word,
  output logic        reject
);

  // Reject stuck words, and repeats unless this is the first word of the key
  always_comb begin
    reject = 1'b0;
    if ((word == WORD_ZERO) || (word == WORD_ONES)) begin
      reject = 1'b1;
    end else if (!first_word && (word == prev_word)) begin
      reject = 1'b1;
    end else begin
      reject = 1'b0;
    end
  end

endmodule

// File: rtl/trng_key_fetch_master.sv
// Wishbone initiator that trims the TRNG ring oscillator, then reads and
// health-checks KEY_WORDS random words and assembles them into a key.
module trng_key_fetch_master
  import trng_key_fetch_master_pkg::*;
#(
  parameter int unsigned KEY_WORDS = 4,
  parameter logic [8:0]  TRNG_ADR  = 9'h000,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                      wb_clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [2:0]                trim_cfg_i,
  trng_key_fetch_master_if.master   wb,
  output logic [32*KEY_WORDS-1:0]   key_o,
  output logic                      key_valid_o,
  output logic                      busy_o,
  output logic                      error_o
);

  localparam int unsigned IDX_W    = $clog2(KEY_WORDS + 1);
  localparam int unsigned RTY_W    = $clog2(MAX_RETRY + 2);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]               state_r;
  logic [IDX_W-1:0]         word_idx_r;
  logic [RTY_W-1:0]         retry_cnt_r;
  logic [7:0]               tmo_cnt_r;
  logic [31:0]              prev_word_r;
  logic [32*KEY_WORDS-1:0]  key_r;
  logic                     key_valid_r;
  logic                     busy_r;
  logic                     error_r;
  logic                     cyc_r;
  logic                     stb_r;
  logic                     we_r;
  logic [8:0]               adr_r;
  logic [31:0]              dat_w_r;

  logic                     ack_s;
  logic                     tmo_hit_s;
  logic                     first_word_s;
  logic                     reject_s;
  logic [IDX_W-1:0]         idx_inc_s;
  logic [RTY_W-1:0]         retry_inc_s;
  logic                     last_word_s;
  logic                     retry_over_s;

  trng_key_fetch_master_health_check u_health (
    .word       (wb.dat_r),
    .prev_word  (prev_word_r),
    .first_word (first_word_s),
    .reject     (reject_s)
  );

  // Decode handshake, timeout expiry and counter increments for the FSM
  always_comb begin
    ack_s        = 1'b0;
    tmo_hit_s    = 1'b0;
    if (cyc_r && stb_r && wb.ack) begin
      ack_s = 1'b1;
    end else begin
      ack_s = 1'b0;
    end
    if (stb_r && !wb.ack && (tmo_cnt_r == TMO_LAST)) begin
      tmo_hit_s = 1'b1;
    end else begin
      tmo_hit_s = 1'b0;
    end
    first_word_s = (word_idx_r == IDX_W'(0));
    idx_inc_s    = word_idx_r + IDX_W'(1);
    retry_inc_s  = retry_cnt_r + RTY_W'(1);
    last_word_s  = (idx_inc_s == IDX_W'(KEY_WORDS));
    retry_over_s = (retry_inc_s > RTY_W'(MAX_RETRY));
  end

  // Main FSM: bus drive, counters, key assembly and status flags
  always_ff @(posedge wb_clk_i) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      word_idx_r  <= IDX_W'(0);
      retry_cnt_r <= RTY_W'(0);
      tmo_cnt_r   <= 8'h00;
      prev_word_r <= 32'h0000_0000;
      key_r       <= '0;
      key_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      error_r     <= 1'b0;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= 9'h000;
      dat_w_r     <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            // adr/dat hold the latched trim for the whole write beat
            key_valid_r <= 1'b0;
            error_r     <= 1'b0;
            key_r       <= '0;
            word_idx_r  <= IDX_W'(0);
            retry_cnt_r <= RTY_W'(0);
            prev_word_r <= 32'h0000_0000;
            tmo_cnt_r   <= 8'h00;
            busy_r      <= 1'b1;
            cyc_r       <= 1'b1;
            stb_r       <= 1'b1;
            we_r        <= 1'b1;
            adr_r       <= {TRNG_ADR[8:2], trim_cfg_i[1:0]};
            dat_w_r     <= trim_wdata(trim_cfg_i);
            state_r     <= ST_TRIM_WR;
          end
        end
        ST_TRIM_WR: begin
          if (ack_s) begin
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            we_r    <= 1'b0;
            state_r <= ST_RD_GAP;
          end else if (tmo_hit_s) begin
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            we_r    <= 1'b0;
            error_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_ERR;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        ST_RD_REQ: begin
          if (ack_s) begin
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            if (!reject_s) begin
              for (int i = 0; i < KEY_WORDS; i++) begin
                if (word_idx_r == IDX_W'(i)) begin
                  key_r[32*i +: 32] <= wb.dat_r;
                end
              end
              prev_word_r <= wb.dat_r;
              word_idx_r  <= idx_inc_s;
              if (last_word_s) begin
                key_valid_r <= 1'b1;
                busy_r      <= 1'b0;
                state_r     <= ST_DONE;
              end else begin
                state_r <= ST_RD_GAP;
              end
            end else begin
              retry_cnt_r <= retry_inc_s;
              if (retry_over_s) begin
                error_r     <= 1'b1;
                key_valid_r <= 1'b0;
                busy_r      <= 1'b0;
                state_r     <= ST_ERR;
              end else begin
                state_r <= ST_RD_GAP;
              end
            end
          end else if (tmo_hit_s) begin
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            error_r     <= 1'b1;
            key_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_ERR;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        ST_RD_GAP: begin
          // One idle cycle lets the slave drop ack before the next beat
          cyc_r     <= 1'b1;
          stb_r     <= 1'b1;
          we_r      <= 1'b0;
          adr_r     <= {TRNG_ADR[8:2], 2'b00};
          dat_w_r   <= 32'h0000_0000;
          tmo_cnt_r <= 8'h00;
          state_r   <= ST_RD_REQ;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        ST_ERR: begin
          state_r <= ST_IDLE;
        end
        default: begin
          cyc_r   <= 1'b0;
          stb_r   <= 1'b0;
          we_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb.cyc      = cyc_r;
  assign wb.stb      = stb_r;
  assign wb.we       = we_r;
  assign wb.adr      = adr_r;
  assign wb.dat_w    = dat_w_r;
  assign key_o       = key_r;
  assign key_valid_o = key_valid_r;
  assign busy_o      = busy_r;
  assign error_o     = error_r;

endmodule

// File: tb/tb_trng_key_fetch_master.sv
// Scoreboard bench for trng_key_fetch_master: a reactive TRNG slave model,
// a key-fetch reference model feeding expected beats/results into queues,
// and monitors that pop and compare as the DUT presents them.
module tb_trng_key_fetch_master;
  localparam int          KW         = 4;
  localparam logic [8:0]  TRNG_ADR_P = 9'h1A4;
  localparam int          TMO        = 255;
  localparam int          MAXR       = 3;

  typedef struct {
    bit          err;
    logic [KW*32-1:0] key;
    int          lat;
  } exp_t;

  typedef struct {
    bit          we;
    logic [8:0]  adr;
    logic [31:0] dat;
    int          len;
  } beat_t;

  logic clk = 1'b0;
  logic rst_ni;
  logic start_i;
  logic [2:0] trim_cfg_i;
  logic [KW*32-1:0] key_o;
  logic key_valid_o, busy_o, error_o;

  trng_key_fetch_master_if wb ();

  trng_key_fetch_master #(
    .KEY_WORDS (KW), .TRNG_ADR (TRNG_ADR_P), .TIMEOUT (TMO), .MAX_RETRY (MAXR)
  ) dut (
    .wb_clk_i    (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .trim_cfg_i  (trim_cfg_i),
    .wb          (wb),
    .key_o       (key_o),
    .key_valid_o (key_valid_o),
    .busy_o      (busy_o),
    .error_o     (error_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_count = 0;
  int start_cyc = 0;
  bit mon_off = 1'b1;

  exp_t        exp_q[$];
  beat_t       beat_q[$];
  logic [31:0] slv_data_q[$];
  int          slv_del_q[$];
  int          slv_trim_del = 1;
  logic [31:0] plan_words[$];
  int          plan_dels[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc_count++;
    end
  end

  // TRNG slave: acks after a planned number of stb cycles, random ack noise while idle
  initial begin
    int stb_cnt;
    int cur_del;
    logic [31:0] cur_dat;
    stb_cnt = 0; cur_del = 0; cur_dat = 32'h0;
    wb.ack = 1'b0;
    wb.dat_r = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (wb.cyc && wb.stb) begin
        if (stb_cnt == 0) begin
          if (wb.we) begin
            cur_del = slv_trim_del;
            cur_dat = $urandom;
          end else if (slv_del_q.size() > 0) begin
            cur_del = slv_del_q.pop_front();
            cur_dat = slv_data_q.pop_front();
          end else begin
            cur_del = 100000;
            cur_dat = 32'h0;
          end
        end
        wb.ack = (stb_cnt >= cur_del);
        wb.dat_r = wb.ack ? cur_dat : $urandom;
        stb_cnt++;
      end else begin
        stb_cnt = 0;
        wb.ack = ($urandom_range(0, 7) == 0);
        wb.dat_r = $urandom;
      end
    end
  end

  // Bus monitor: measures each beat and compares it with the expected beat
  initial begin
    bit in_beat;
    int b_len;
    int nocyc;
    beat_t got, e;
    in_beat = 1'b0; b_len = 0; nocyc = 0;
    forever begin
      @(negedge clk);
      if (mon_off) begin
        in_beat = 1'b0;
        nocyc = 0;
      end else begin
        if (wb.stb && !wb.cyc) nocyc++;
        if (wb.stb) begin
          if (!in_beat) begin
            in_beat = 1'b1;
            b_len = 0;
            got.we = wb.we;
            got.adr = wb.adr;
            got.dat = wb.dat_w;
          end
          b_len++;
        end else if (in_beat) begin
          in_beat = 1'b0;
          check("stb_without_cyc", nocyc, 0);
          if (beat_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = beat_q.pop_front();
            check("beat_we", got.we, e.we);
            check("beat_adr", got.adr, e.adr);
            check("beat_len", b_len, e.len);
            if (e.we) check("trim_dat", got.dat, e.dat);
          end
        end
      end
    end
  end

  // Result monitor: on key_valid_o or error_o rising, pop and compare the expected result
  initial begin
    bit kv_q, er_q;
    exp_t e;
    kv_q = 1'b0; er_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_off && ((key_valid_o && !kv_q) || (error_o && !er_q))) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("error_o", error_o, e.err);
          check("key_valid_o", key_valid_o, !e.err);
          check("key_o", key_o, e.key);
          check("latency", cyc_count - start_cyc - 1, e.lat);
          check("busy_o_at_done", busy_o, 1'b0);
          check("cyc_at_done", wb.cyc, 1'b0);
        end
      end
      kv_q = key_valid_o;
      er_q = error_o;
    end
  end

  // Reference model over the plan, expected pushes, then start and bounded wait
  task automatic do_fetch(input logic [2:0] trim, input int trim_d, input bit busy_poke, input bit done_poke);
    exp_t e;
    beat_t b;
    int acc, rej, d;
    bit fin, is_bad, seen;
    logic [31:0] prev, w;
    slv_data_q.delete();
    slv_del_q.delete();
    slv_trim_del = trim_d;
    e.err = 1'b0; e.key = '0; acc = 0; rej = 0; fin = 1'b0; prev = 32'h0;
    b.we = 1'b1;
    b.adr = (TRNG_ADR_P & 9'h1FC) | 9'(trim[1:0]);
    b.dat = (32'(trim[2]) << 5) | 32'(trim[1:0]);
    b.len = trim_d + 1;
    beat_q.push_back(b);
    e.lat = b.len;
    for (int i = 0; i < plan_words.size() && !fin; i++) begin
      w = plan_words[i];
      d = plan_dels[i];
      slv_data_q.push_back(w);
      slv_del_q.push_back(d);
      b.we = 1'b0;
      b.adr = TRNG_ADR_P & 9'h1FC;
      b.dat = 32'h0;
      if (d + 1 > TMO) begin
        b.len = TMO;
        e.err = 1'b1;
        fin = 1'b1;
      end else begin
        b.len = d + 1;
        is_bad = (w == 32'h0) || (w == 32'hFFFF_FFFF) || (acc > 0 && w == prev);
        if (is_bad) begin
          rej++;
          if (rej > MAXR) begin
            e.err = 1'b1;
            fin = 1'b1;
          end
        end else begin
          e.key[acc*32 +: 32] = w;
          prev = w;
          acc++;
          if (acc == KW) fin = 1'b1;
        end
      end
      beat_q.push_back(b);
      e.lat += 1 + b.len;
    end
    exp_q.push_back(e);

    @(negedge clk);
    start_i = 1'b1;
    trim_cfg_i = trim;
    start_cyc = cyc_count;
    @(negedge clk);
    start_i = 1'b0;
    trim_cfg_i = $urandom;
    if (busy_poke) begin
      repeat (3) @(negedge clk);
      start_i = 1'b1;
      trim_cfg_i = ~trim;
      @(negedge clk);
      start_i = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (key_valid_o || error_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("fetch_completes", seen, 1'b1);
    if (done_poke) begin
      start_i = 1'b1;
      trim_cfg_i = ~trim;
      @(negedge clk);
      start_i = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("no_restart", {busy_o, wb.cyc}, 2'b00);
    check("beats_consumed", beat_q.size(), 0);
  endtask

  task automatic plan_good(input int del);
    plan_words.delete();
    plan_dels.delete();
    for (int i = 0; i < KW; i++) begin
      plan_words.push_back(32'h1000_0000 + 32'($urandom_range(1, 16'hFFFF)) + 32'(i << 20));
      plan_dels.push_back(del);
    end
  endtask

  initial begin
    logic [31:0] w, last;
    bit found;
    rst_ni = 1'b0;
    start_i = 1'b0;
    trim_cfg_i = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_cyc", wb.cyc, 1'b0);
    check("rst_stb", wb.stb, 1'b0);
    check("rst_we", wb.we, 1'b0);
    check("rst_adr", wb.adr, 9'h000);
    check("rst_dat", wb.dat_w, 32'h0);
    check("rst_key", key_o, '0);
    check("rst_flags", {key_valid_o, busy_o, error_o}, 3'b000);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    mon_off = 1'b0;

    // Minimum latency, trim 3'b101, start during DONE ignored
    plan_good(1);
    do_fetch(3'b101, 1, 1'b0, 1'b1);

    // Rejections mixed in, start while busy ignored
    plan_words = '{32'h1111_1111, 32'h0000_0000, 32'h2222_2222, 32'h2222_2222,
                   32'h3333_3333, 32'h4444_4444};
    plan_dels = '{1, 1, 1, 1, 1, 1};
    do_fetch(3'b010, 1, 1'b1, 1'b0);

    // Retry limit exceeded
    plan_words = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    plan_dels = '{1, 1, 1, 1, 1};
    do_fetch(3'b111, 1, 1'b0, 1'b0);

    // Timeout on second read, then ack on the last allowed cycle
    plan_good(1);
    plan_dels[1] = 1000;
    do_fetch(3'b011, 2, 1'b0, 1'b0);
    plan_good(1);
    plan_dels[1] = TMO - 1;
    do_fetch(3'b100, 0, 1'b0, 1'b0);

    // Randomized fetches
    for (int n = 0; n < 20; n++) begin
      plan_words.delete();
      plan_dels.delete();
      last = 32'h5A5A_0001;
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 9))
          0: w = 32'h0000_0000;
          1: w = 32'hFFFF_FFFF;
          2: w = last;
          default: w = $urandom;
        endcase
        last = w;
        plan_words.push_back(w);
        plan_dels.push_back($urandom_range(0, 4));
      end
      do_fetch(3'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end

    // Synchronous reset in the middle of a read beat
    mon_off = 1'b1;
    beat_q.delete();
    exp_q.delete();
    slv_data_q.delete();
    slv_del_q.delete();
    slv_trim_del = 1;
    for (int i = 0; i < KW; i++) begin
      slv_data_q.push_back(32'hABC0_0001 + 32'(i));
      slv_del_q.push_back(6);
    end
    @(negedge clk);
    start_i = 1'b1;
    trim_cfg_i = 3'b001;
    @(negedge clk);
    start_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (key_o != '0 && wb.stb && !wb.we) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reached_rd_req", found, 1'b1);
    rst_ni = 1'b0;
    @(negedge clk);
    check("midrst_cyc_stb", {wb.cyc, wb.stb}, 2'b00);
    check("midrst_key", key_o, '0);
    check("midrst_flags", {key_valid_o, busy_o, error_o}, 3'b000);
    rst_ni = 1'b1;
    slv_data_q.delete();
    slv_del_q.delete();
    repeat (3) @(negedge clk);
    mon_off = 1'b0;

    // Normal fetch after the reset
    plan_good(2);
    do_fetch(3'b110, 1, 1'b0, 1'b0);
    check("results_consumed", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
